// File: rtl/risk_pkg.sv
// Shared encodings, widths and the tile word type for the RISK strided tile sequencer.
package risk_pkg;

  localparam int TILE      = 4;
  localparam int ELEM_W    = 18;
  localparam int BANK_BITS = 5;
  localparam int ADDR_W    = 15;
  localparam int STRIDE_W  = 14;
  localparam int TILE_W    = TILE * TILE * ELEM_W;

  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ZERO  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/risk_bank_check.sv
// Flags a descriptor whose 16 tile element addresses do not land in 16 distinct banks.
module risk_bank_check
  import risk_pkg::*;
(
  input  logic [ADDR_W-1:0]   base,
  input  logic [STRIDE_W-1:0] sx,
  input  logic [STRIDE_W-1:0] sy,
  output logic                conflict
);

  logic [BANK_BITS-1:0] bank [TILE*TILE];

  // Only the low bank bits of each address term can influence the bank index.
  for (genvar y = 0; y < TILE; y++) begin : g_y
    for (genvar x = 0; x < TILE; x++) begin : g_x
      assign bank[y*TILE+x] = base[BANK_BITS-1:0]
                            + sx[BANK_BITS-1:0] * BANK_BITS'(x)
                            + sy[BANK_BITS-1:0] * BANK_BITS'(y);
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < TILE*TILE; i++) begin
      for (int j = i + 1; j < TILE*TILE; j++) begin
        if (bank[i] == bank[j]) conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/risk_tile_seq.sv
// Tile-walk sequencer: one bank check per descriptor, then one tile access per cycle,
// with load data written back to the register file RD_LAT cycles after issue.
//   state | meaning
//   IDLE  | ready for a descriptor
//   CHECK | bank-conflict / opcode check on the latched descriptor
//   ISSUE | one tile per cycle, down-counter of remaining tiles
//   DRAIN | wait for in-flight loads (store/zero pass through in one cycle)
module risk_tile_seq
  import risk_pkg::*;
#(
  parameter int RD_LAT = 4,
  parameter int NREGS  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(NREGS)-1:0]   cmd_reg,
  input  logic [ADDR_W-1:0]          cmd_base,
  input  logic [STRIDE_W-1:0]        cmd_stride_x,
  input  logic [STRIDE_W-1:0]        cmd_stride_y,
  input  logic [ADDR_W-1:0]          cmd_step,
  input  logic [7:0]                 cmd_count,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [STRIDE_W-1:0]        mem_stride_x,
  output logic [STRIDE_W-1:0]        mem_stride_y,
  output logic                       mem_we,
  output logic [TILE_W-1:0]          mem_dat_w,
  input  logic [TILE_W-1:0]          mem_dat_r,
  output logic [$clog2(NREGS)-1:0]   rf_ridx,
  input  logic [TILE_W-1:0]          rf_rdata,
  output logic                       rf_we,
  output logic [$clog2(NREGS)-1:0]   rf_widx,
  output logic [TILE_W-1:0]          rf_wdata
);

  localparam int IDX_W = $clog2(NREGS);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] step_q;
  logic [7:0]        cnt_q;
  logic              conflict;
  logic              accept;
  logic              issue;
  logic              err_d;
  logic              done_d;
  logic              drain_empty;

  logic              ld_vld_q;
  logic [IDX_W-1:0]  ld_tag_q;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [IDX_W-1:0]  pipe_tag_q [RD_LAT];

  // addr_q still holds the base while in CHECK.
  risk_bank_check u_bank_check (
    .base     (addr_q),
    .sx       (mem_stride_x),
    .sy       (mem_stride_y),
    .conflict (conflict)
  );

  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign issue     = (state_q == S_ISSUE);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rf_ridx   = idx_q;

  // Empty once only the writeback stage (if anything) is still occupied.
  assign drain_empty = !ld_vld_q && ((pipe_vld_q << 1) == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (conflict || op_q == OP_RSVD) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 8'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= OP_LOAD;
      idx_q        <= '0;
      addr_q       <= '0;
      step_q       <= '0;
      cnt_q        <= '0;
      err          <= 1'b0;
      done         <= 1'b0;
      mem_addr     <= '0;
      mem_stride_x <= '0;
      mem_stride_y <= '0;
      mem_we       <= 1'b0;
      mem_dat_w    <= '0;
    end else begin
      err    <= err_d;
      done   <= done_d;
      mem_we <= 1'b0;
      if (accept) begin
        op_q         <= op_e'(cmd_op);
        idx_q        <= cmd_reg;
        addr_q       <= cmd_base;
        step_q       <= cmd_step;
        cnt_q        <= cmd_count;
        mem_stride_x <= cmd_stride_x;
        mem_stride_y <= cmd_stride_y;
      end
      if (issue) begin
        mem_addr <= addr_q;
        mem_we   <= (op_q != OP_LOAD);
        if (op_q != OP_LOAD) mem_dat_w <= (op_q == OP_STORE) ? rf_rdata : '0;
        addr_q   <= addr_q + step_q;
        idx_q    <= (idx_q == IDX_W'(NREGS - 1)) ? '0 : idx_q + 1'b1;
        cnt_q    <= cnt_q - 8'd1;
      end
    end
  end

  // ld_vld_q rides with mem_addr; RD_LAT more stages line the tag up with mem_dat_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_vld_q   <= 1'b0;
      ld_tag_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      ld_vld_q      <= issue && (op_q == OP_LOAD);
      ld_tag_q      <= idx_q;
      pipe_vld_q[0] <= ld_vld_q;
      pipe_tag_q[0] <= ld_tag_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign rf_we    = pipe_vld_q[RD_LAT-1];
  assign rf_widx  = rf_we ? pipe_tag_q[RD_LAT-1] : '0;
  assign rf_wdata = rf_we ? mem_dat_r : '0;

endmodule

// File: tb/tb_risk_tile_seq.sv
// Directed bench for risk_tile_seq with a fixed-latency memory model and a pattern register file.
module tb_risk_tile_seq;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [1:0]    cmd_reg;
  logic [14:0]   cmd_base;
  logic [13:0]   cmd_stride_x;
  logic [13:0]   cmd_stride_y;
  logic [14:0]   cmd_step;
  logic [7:0]    cmd_count;
  logic          busy, done, err;
  logic [14:0]   mem_addr;
  logic [13:0]   mem_stride_x, mem_stride_y;
  logic          mem_we;
  logic [287:0]  mem_dat_w, mem_dat_r;
  logic [1:0]    rf_ridx;
  logic [287:0]  rf_rdata;
  logic          rf_we;
  logic [1:0]    rf_widx;
  logic [287:0]  rf_wdata;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_err = 0, n_mem_we = 0, n_rf_we = 0;
  int b_done, b_err, b_mem_we, b_rf_we;

  logic [14:0] hist [4] = '{default: 15'd0};

  always #5 clk = ~clk;

  risk_tile_seq #(.RD_LAT(4), .NREGS(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .cmd_base(cmd_base), .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
    .cmd_step(cmd_step), .cmd_count(cmd_count),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_stride_x(mem_stride_x), .mem_stride_y(mem_stride_y),
    .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r),
    .rf_ridx(rf_ridx), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_widx(rf_widx), .rf_wdata(rf_wdata)
  );

  function automatic logic [287:0] mpat(input logic [14:0] a);
    logic [287:0] t;
    for (int k = 0; k < 16; k++) t[18*k +: 18] = {a[13:0], 4'(k)};
    return t;
  endfunction

  function automatic logic [287:0] rf_init(input logic [1:0] r);
    logic [287:0] t;
    for (int k = 0; k < 16; k++) t[18*k +: 18] = {2'b10, 6'(r), 4'(k), 6'h15};
    return t;
  endfunction

  // Memory returns data for the address presented four cycles earlier.
  always @(posedge clk) begin
    hist[0] <= mem_addr;
    for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
  end
  assign mem_dat_r = mpat(hist[3]);
  assign rf_rdata  = rf_init(rf_ridx);

  always @(posedge clk) begin
    if (done)   n_done++;
    if (err)    n_err++;
    if (mem_we) n_mem_we++;
    if (rf_we)  n_rf_we++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkt(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_done = n_done; b_err = n_err; b_mem_we = n_mem_we; b_rf_we = n_rf_we;
  endtask

  // Returns in the cycle after the accept edge (the CHECK cycle).
  task automatic send(input logic [1:0] op, input logic [1:0] r, input logic [14:0] base,
                      input logic [13:0] sx, input logic [13:0] sy,
                      input logic [14:0] step, input logic [7:0] cnt);
    cmd_op = op; cmd_reg = r; cmd_base = base; cmd_stride_x = sx; cmd_stride_y = sy;
    cmd_step = step; cmd_count = cnt; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_base = '0;
    cmd_stride_x = '0; cmd_stride_y = '0; cmd_step = '0; cmd_count = '0;
    cyc(3);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({done, err, mem_we, rf_we}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_strides", 32'({mem_stride_x, mem_stride_y}), 0);
    chk("rst_idx", 32'({rf_ridx, rf_widx}), 0);
    chkt("rst_dat_w", mem_dat_w, '0);
    chkt("rst_wdata", rf_wdata, '0);
    reset = 1'b0;
    cyc(1);

    // Load, 3 tiles from reg 2
    snap();
    send(2'b00, 2'd2, 15'h0000, 14'd1, 14'd4, 15'd16, 8'd3);
    chk("ld_busy", 32'(busy), 1);
    chk("ld_ready", 32'(cmd_ready), 0);
    cyc(1);
    chk("ld_no_err", 32'(err), 0);
    cyc(1);
    chk("ld_addr0", 32'(mem_addr), 32'h0);
    chk("ld_we0", 32'(mem_we), 0);
    chk("ld_sx", 32'(mem_stride_x), 1);
    chk("ld_sy", 32'(mem_stride_y), 4);
    cyc(1);
    chk("ld_addr1", 32'(mem_addr), 32'h10);
    cyc(1);
    chk("ld_addr2", 32'(mem_addr), 32'h20);
    cyc(2);
    chk("ld_rfwe0", 32'(rf_we), 1);
    chk("ld_widx0", 32'(rf_widx), 2);
    chkt("ld_wdata0", rf_wdata, mpat(15'h0000));
    cyc(1);
    chk("ld_widx1", 32'(rf_widx), 3);
    chkt("ld_wdata1", rf_wdata, mpat(15'h0010));
    cyc(1);
    chk("ld_rfwe2", 32'(rf_we), 1);
    chk("ld_widx2", 32'(rf_widx), 0);
    chkt("ld_wdata2", rf_wdata, mpat(15'h0020));
    chk("ld_done_early", 32'(done), 0);
    cyc(1);
    chk("ld_done", 32'(done), 1);
    chk("ld_rfwe_end", 32'(rf_we), 0);
    cyc(1);
    chk("ld_done_pulse", 32'(done), 0);
    chk("ld_done_cnt", 32'(n_done - b_done), 1);
    chk("ld_rfwe_cnt", 32'(n_rf_we - b_rf_we), 3);
    chk("ld_memwe_cnt", 32'(n_mem_we - b_mem_we), 0);

    // Bank conflict: sx 16 puts x=0 and x=2 in bank 0
    snap();
    send(2'b00, 2'd0, 15'h0000, 14'd16, 14'd1, 15'd16, 8'd3);
    chk("cf_err_early", 32'(err), 0);
    cyc(1);
    chk("cf_err", 32'(err), 1);
    chk("cf_ready", 32'(cmd_ready), 1);
    cyc(1);
    chk("cf_err_pulse", 32'(err), 0);
    cyc(8);
    chk("cf_memwe_cnt", 32'(n_mem_we - b_mem_we), 0);
    chk("cf_rfwe_cnt", 32'(n_rf_we - b_rf_we), 0);
    chk("cf_done_cnt", 32'(n_done - b_done), 0);
    chk("cf_err_cnt", 32'(n_err - b_err), 1);

    // Store, 2 tiles from reg 1
    snap();
    send(2'b01, 2'd1, 15'h0100, 14'd1, 14'd4, 15'd16, 8'd2);
    cyc(2);
    chk("st_we0", 32'(mem_we), 1);
    chk("st_addr0", 32'(mem_addr), 32'h100);
    chkt("st_dat0", mem_dat_w, rf_init(2'd1));
    cyc(1);
    chk("st_we1", 32'(mem_we), 1);
    chk("st_addr1", 32'(mem_addr), 32'h110);
    chkt("st_dat1", mem_dat_w, rf_init(2'd2));
    cyc(1);
    chk("st_done", 32'(done), 1);
    chk("st_we_end", 32'(mem_we), 0);
    cyc(2);
    chk("st_memwe_cnt", 32'(n_mem_we - b_mem_we), 2);
    chk("st_rfwe_cnt", 32'(n_rf_we - b_rf_we), 0);

    // Zero op wrapping the 15-bit address space
    send(2'b10, 2'd0, 15'h7FF0, 14'd1, 14'd4, 15'h0020, 8'd2);
    cyc(2);
    chk("zw_addr0", 32'(mem_addr), 32'h7FF0);
    chk("zw_we0", 32'(mem_we), 1);
    chkt("zw_dat0", mem_dat_w, '0);
    cyc(1);
    chk("zw_addr1", 32'(mem_addr), 32'h0010);
    chkt("zw_dat1", mem_dat_w, '0);
    cyc(1);
    chk("zw_done", 32'(done), 1);
    cyc(1);

    // Zero-length descriptor, then reserved opcode
    snap();
    send(2'b00, 2'd0, 15'h0000, 14'd1, 14'd4, 15'd16, 8'd0);
    chk("c0_done_early", 32'(done), 0);
    cyc(1);
    chk("c0_done", 32'(done), 1);
    chk("c0_err", 32'(err), 0);
    cyc(1);
    send(2'b11, 2'd0, 15'h0000, 14'd1, 14'd4, 15'd16, 8'd1);
    cyc(1);
    chk("rsv_err", 32'(err), 1);
    chk("rsv_done", 32'(done), 0);
    cyc(6);
    chk("c0_rsv_memwe_cnt", 32'(n_mem_we - b_mem_we), 0);
    chk("c0_rsv_rfwe_cnt", 32'(n_rf_we - b_rf_we), 0);

    // Reset while draining two in-flight loads
    snap();
    send(2'b00, 2'd0, 15'h0040, 14'd1, 14'd4, 15'd16, 8'd2);
    cyc(4);
    chk("rd_busy", 32'(busy), 1);
    chk("rd_rfwe_pre", 32'(rf_we), 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("rd_ready", 32'(cmd_ready), 1);
    chk("rd_busy_after", 32'(busy), 0);
    cyc(8);
    chk("rd_rfwe_cnt", 32'(n_rf_we - b_rf_we), 0);
    chk("rd_done_cnt", 32'(n_done - b_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
